// File: rtl/rom_arb_pkg.sv
// Shared types for the ROM fetch arbiter: default widths, control states and
// the record carried through the first pipeline stage.
package rom_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 32;
  // Enough to index up to 8 requesters.
  localparam int unsigned STAGE_ID_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [STAGE_ID_W-1:0] id;
    logic                  err;
  } stage_t;

endpackage

// File: rtl/rom_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin selector: the first requester at or after ptr
// (wrapping) wins; the pointer register lives in the parent.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N-1:0] rot;
  logic         found;
  int unsigned  abs_idx;

  // Rotate so the pointer position sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot     = N'({req_i, req_i} >> ptr_i);
    gnt_o   = '0;
    idx_o   = '0;
    found   = 1'b0;
    abs_idx = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (en_i && !found && rot[i]) begin
        found   = 1'b1;
        abs_idx = (32'(ptr_i) + i) % N;
        gnt_o   = N'(1) << abs_idx;
        idx_o   = IDX_W'(abs_idx);
      end
    end
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between fetch requesters,
// with a two-cycle response pipeline and a drain-then-halt shutdown sequence.
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ID_W    = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      rsp_valid_o,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_err_o,
  input  logic                      finish_i,
  output logic [ADDR_W-1:0]         rom_addr_o,
  output logic                      rom_finish_o,
  input  logic [DATA_W-1:0]         rom_data_i,
  output logic                      halted_o
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_next, gnt_idx;
  logic [NUM_REQ-1:0]  gnt;
  logic                grant_en_c, hs_c;
  logic [ADDR_W-1:0]   addr_sel;
  stage_t              s1_q;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (grant_en_c),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign req_ready_o = gnt;
  assign hs_c        = |gnt;
  assign ptr_next    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

  always_comb begin
    addr_sel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) addr_sel = req_addr_i[k*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // No grants issue once draining, so an empty stage 1 means stage 2 empties on this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (finish_i) state_d = ST_DRAIN;
      ST_DRAIN:  if (!s1_q.valid) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Finish wins over any request presented in the same cycle.
  always_comb begin
    grant_en_c = 1'b0;
    if (state_q == ST_RUN && !finish_i) grant_en_c = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rom_finish_o <= 1'b0;
      halted_o     <= 1'b0;
    end else begin
      rom_finish_o <= (state_d == ST_HALTED);
      halted_o     <= (state_d == ST_HALTED);
    end
  end

  // Stage 1 captures the granted address; stage 2 captures the settled ROM word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q       <= '0;
      s1_q        <= '0;
      rom_addr_o  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_err_o   <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      s1_q.valid  <= hs_c;
      s1_q.id     <= STAGE_ID_W'(gnt_idx);
      s1_q.err    <= hs_c && (addr_sel[1:0] != 2'b00);
      if (hs_c) begin
        rom_addr_o <= addr_sel;
        ptr_q      <= ptr_next;
      end
      rsp_valid_o <= s1_q.valid;
      rsp_err_o   <= s1_q.valid && s1_q.err;
      if (s1_q.valid) begin
        rsp_data_o <= rom_data_i;
        rsp_id_o   <= ID_W'(s1_q.id);
      end
    end
  end

endmodule
